scan_chain_ctrl: RTL and testbench
==================================

// Module: scan_chain_ctrl
// PURPOSE
// - Sequences a serial chain of CHAIN_LEN DFFX1-based scan flops for power and functional characterisation.
// - One request runs in this order:
//   - shift a parallel pattern into the chain;
//   - optionally pulse one functional capture cycle;
//   - return the bits shifted out of the chain as a parallel word.
// - Sits between the test host (start/done handshake) and the chain's scan_en/scan_in/scan_out pins.
// PARAMETERS
// - CHAIN_LEN  default 16  number of flops in the chain; legal range 2..256.
// - CNT_W      default 8   shift counter width; must satisfy 2**CNT_W > CHAIN_LEN.
// PORTS
// - CLK          in   1          rising-edge clock shared with the chain
// - RSTB         in   1          asynchronous, active-low reset
// - start        in   1          request pulse, sampled in IDLE only
// - capture_req  in   1          sampled with start; 1 = insert a CAPTURE cycle after the shift
// - load_data    in   CHAIN_LEN  pattern to shift in, sampled with start
// - busy         out  1          high from the cycle after an accepted start until DONE is left
// - done         out  1          one-cycle pulse; unload_data is valid from this cycle
// - unload_data  out  CHAIN_LEN  bits collected from scan_out
// - scan_en      out  1          chain shift enable
// - scan_in      out  1          serial data into the chain head
// - cap_en       out  1          one-cycle functional-capture enable to the chain
// - scan_out     in   1          serial data from the chain tail
// BEHAVIOUR
// - Reset (RSTB low, asynchronous): all outputs are 0, unload_data is 0, state is IDLE, counter is 0.
// - Deassertion of RSTB takes effect at the next CLK edge.
// - FSM states: IDLE, SHIFT, CAPTURE, DONE.
//   - IDLE, start=1: latch load_data into pat_q and capture_req into cap_q; clear counter; go to SHIFT.
//   - SHIFT: scan_en=1 and scan_in=pat_q[cnt].
//     - On each edge: unload_q[cnt] <= scan_out, then cnt <= cnt+1.
//     - When cnt==CHAIN_LEN-1: go to CAPTURE if cap_q, else DONE.
//   - CAPTURE: exactly one cycle; scan_en=0, cap_en=1; then DONE.
//   - DONE: exactly one cycle; done=1; unload_data=unload_q; then IDLE.
// - Latency from the start edge to the done cycle: CHAIN_LEN+1 cycles without capture, CHAIN_LEN+2 with capture.
// - start outside IDLE is ignored and is not queued.
// - start in DONE is also ignored; a back-to-back request needs start on the following IDLE cycle.
// - unload_data holds its value until the next DONE; it does not change during a later SHIFT.
// - Output timing:
//   - scan_en, scan_in and cap_en are registered (glitch-free) and change only on CLK rise.
//   - scan_in for cnt==k is driven during the k-th SHIFT cycle.
// - Width rules:
//   - cnt is CNT_W bits, compared to CHAIN_LEN-1, and never wraps inside SHIFT.
//   - cnt index into pat_q/unload_q is always < CHAIN_LEN.
// - Reset mid-operation aborts immediately:
//   - scan_en and cap_en drop asynchronously;
//   - the chain contents are left as-is;
//   - no done pulse is produced.
// - X on scan_out is stored as-is into unload_q; the controller does not filter it.
// STRUCTURE
// - Shared package scan_ctrl_pkg:
//   - state enum scan_state_t {IDLE, SHIFT, CAPTURE, DONE}, 2 bits;
//   - localparam MAX_CHAIN_LEN=256.
// - One sub-module, scan_shift_counter:
//   - CNT_W-bit up-counter with clear, enable and a last (==CHAIN_LEN-1) flag;
//   - used by the FSM for the terminal-count decision.
// - FSM, pat_q, unload_q and the registered outputs live in the top module.
// TESTING
// - Bench chain: CHAIN_LEN DFFX1-equivalent flops with a scan mux.
//   - Capture path loads ~Q, so that a capture is observable.
// - T1 reset: RSTB=0 mid-SHIFT -> scan_en, cap_en, busy and done are 0 within the same time step.
//   - Next start runs normally.
// - T2 shift only: chain preloaded 16'h0000, start with load_data=16'hA5C3, capture_req=0.
//   - done arrives 17 cycles after the start edge.
//   - unload_data=16'h0000.
//   - A second run with 16'h0000 returns 16'hA5C3.
// - T3 capture: chain holds 16'h00FF, start with load_data=16'h00FF, capture_req=1.
//   - cap_en is high for exactly 1 cycle, after 16 scan_en cycles.
//   - The next shift-only run returns 16'hFF00.
// - T4 ignored start: pulse start during SHIFT and during DONE.
//   - busy and cnt are unaffected and exactly one done pulse is produced.
//   - Check: no implicit second run.
// - T5 boundary: CHAIN_LEN=2, CNT_W=2, load_data=2'b10.
//   - scan_in sequence is 0,1.
//   - done arrives 3 cycles after start.
//   - cnt never exceeds 1.
// - T6 back-to-back: start asserted on the first IDLE cycle after DONE.
//   - Accepted; busy is low for exactly 1 cycle between runs.

Source files
------------

// File: rtl/scan_ctrl_pkg.sv
// Shared types and limits for the scan chain controller.
// The state encoding is used by the controller FSM in scan_chain_ctrl.
package scan_ctrl_pkg;

    localparam int MAX_CHAIN_LEN = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } scan_state_t;

endpackage

// File: rtl/scan_shift_counter.sv
// Shift position counter for the scan controller.
// It saturates at CHAIN_LEN-1, so the bit index it reports always stays inside the chain.
module scan_shift_counter #(
    parameter int CHAIN_LEN = 16,
    parameter int CNT_W     = 8,
    parameter int IDX_W     = 4
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             clr,
    input  logic             en,
    output logic [IDX_W-1:0] idx,
    output logic [IDX_W-1:0] next_idx,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST_CNT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last     = (cnt_q == LAST_CNT);
    assign idx      = cnt_q[IDX_W-1:0];
    assign next_idx = cnt_d[IDX_W-1:0];

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: shifts a pattern into the chain, optionally pulses one
// capture cycle, and returns the bits shifted out as a parallel word.
module scan_chain_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 16,
    parameter int CNT_W     = 8
) (
    input  logic                 CLK,
    input  logic                 RSTB,
    input  logic                 start,
    input  logic                 capture_req,
    input  logic [CHAIN_LEN-1:0] load_data,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] unload_data,
    output logic                 scan_en,
    output logic                 scan_in,
    output logic                 cap_en,
    input  logic                 scan_out
);

    localparam int IDX_W = $clog2(CHAIN_LEN);

    scan_state_t          state_q, state_d;
    logic [CHAIN_LEN-1:0] pat_q, pat_d;
    logic                 cap_q, cap_d;
    logic [CHAIN_LEN-1:0] unload_q, unload_d;
    logic [CHAIN_LEN-1:0] unload_data_q, unload_data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 scan_en_q, scan_en_d;
    logic                 scan_in_q, scan_in_d;
    logic                 cap_en_q, cap_en_d;

    logic                 cnt_clr;
    logic                 cnt_en;
    logic [IDX_W-1:0]     cnt_idx;
    logic [IDX_W-1:0]     cnt_next_idx;
    logic                 cnt_last;

    scan_shift_counter #(
        .CHAIN_LEN (CHAIN_LEN),
        .CNT_W     (CNT_W),
        .IDX_W     (IDX_W)
    ) u_cnt (
        .CLK      (CLK),
        .RSTB     (RSTB),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .idx      (cnt_idx),
        .next_idx (cnt_next_idx),
        .last     (cnt_last)
    );

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        cap_d    = cap_q;
        unload_d = unload_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d   = load_data;
                    cap_d   = capture_req;
                    cnt_clr = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                unload_d[cnt_idx] = scan_out;
                if (cnt_last) begin
                    state_d = cap_q ? CAPTURE : DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            CAPTURE: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with the state itself.
    always_comb begin
        busy_d        = (state_d != IDLE);
        done_d        = (state_d == DONE);
        scan_en_d     = (state_d == SHIFT);
        cap_en_d      = (state_d == CAPTURE);
        scan_in_d     = (state_d == SHIFT) ? pat_d[cnt_next_idx] : 1'b0;
        unload_data_d = (state_d == DONE) ? unload_d : unload_data_q;
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q       <= IDLE;
            pat_q         <= '0;
            cap_q         <= 1'b0;
            unload_q      <= '0;
            unload_data_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            scan_en_q     <= 1'b0;
            scan_in_q     <= 1'b0;
            cap_en_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pat_q         <= pat_d;
            cap_q         <= cap_d;
            unload_q      <= unload_d;
            unload_data_q <= unload_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            scan_en_q     <= scan_en_d;
            scan_in_q     <= scan_in_d;
            cap_en_q      <= cap_en_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign unload_data = unload_data_q;
    assign scan_en     = scan_en_q;
    assign scan_in     = scan_in_q;
    assign cap_en      = cap_en_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: two instances (16-flop and 2-flop chains) driving
// behavioural scan chains whose capture path loads the inverted contents.
module tb_scan_chain_ctrl;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RSTB = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        start1 = 1'b0;
    logic        capreq1 = 1'b0;
    logic [15:0] load1 = '0;
    logic        busy1, done1, scan_en1, scan_in1, cap_en1, scan_out1;
    logic [15:0] unload1;

    logic        start2 = 1'b0;
    logic        capreq2 = 1'b0;
    logic [1:0]  load2 = '0;
    logic        busy2, done2, scan_en2, scan_in2, cap_en2, scan_out2;
    logic [1:0]  unload2;

    logic [15:0] ch1;
    logic        pre1_en = 1'b0;
    logic [15:0] pre1_val = '0;
    logic [1:0]  ch2;
    logic        pre2_en = 1'b0;
    logic [1:0]  pre2_val = '0;

    exp_t        q1[$];
    exp_t        q2[$];
    exp_t        e1, e2;

    int          en_cnt, cap_cnt, en_at_cap, busy_low;
    logic [1:0]  sin_seq;
    int          cnt2_max = 0;
    bit          seen;

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    scan_chain_ctrl #(.CHAIN_LEN(16), .CNT_W(8)) dut1 (
        .CLK(CLK), .RSTB(RSTB), .start(start1), .capture_req(capreq1),
        .load_data(load1), .busy(busy1), .done(done1), .unload_data(unload1),
        .scan_en(scan_en1), .scan_in(scan_in1), .cap_en(cap_en1), .scan_out(scan_out1)
    );

    scan_chain_ctrl #(.CHAIN_LEN(2), .CNT_W(2)) dut2 (
        .CLK(CLK), .RSTB(RSTB), .start(start2), .capture_req(capreq2),
        .load_data(load2), .busy(busy2), .done(done2), .unload_data(unload2),
        .scan_en(scan_en2), .scan_in(scan_in2), .cap_en(cap_en2), .scan_out(scan_out2)
    );

    // Behavioural chains: head is bit 0, tail (scan_out) is the MSB.
    always @(posedge CLK) begin
        if (pre1_en)       ch1 <= pre1_val;
        else if (scan_en1) ch1 <= {ch1[14:0], scan_in1};
        else if (cap_en1)  ch1 <= ~ch1;
    end
    assign scan_out1 = ch1[15];

    always @(posedge CLK) begin
        if (pre2_en)       ch2 <= pre2_val;
        else if (scan_en2) ch2 <= {ch2[0], scan_in2};
        else if (cap_en2)  ch2 <= ~ch2;
    end
    assign scan_out2 = ch2[1];

    always @(negedge CLK) begin
        if (dut2.u_cnt.cnt_q > cnt2_max) cnt2_max = int'(dut2.u_cnt.cnt_q);
    end

    // Scoreboard monitors: each done pulse pops one expectation.
    always @(negedge CLK) begin
        if (done1 === 1'b1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_done1 at cycle %0d: got done=1, required no done", cyc);
            end else begin
                e1 = q1.pop_front();
                if (unload1 !== e1.data) begin
                    errors++;
                    $display("[TB] FAIL unload1: got %h, required %h", unload1, e1.data);
                end
                checks++;
                if (cyc != e1.due) begin
                    errors++;
                    $display("[TB] FAIL latency1: done at cycle %0d, required %0d", cyc, e1.due);
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (done2 === 1'b1) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_done2 at cycle %0d: got done=1, required no done", cyc);
            end else begin
                e2 = q2.pop_front();
                if (unload2 !== e2.data[1:0]) begin
                    errors++;
                    $display("[TB] FAIL unload2: got %b, required %b", unload2, e2.data[1:0]);
                end
                checks++;
                if (cyc != e2.due) begin
                    errors++;
                    $display("[TB] FAIL latency2: done at cycle %0d, required %0d", cyc, e2.due);
                end
            end
        end
    end

    function automatic logic [15:0] rev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Preload so that the next unload of the chain returns 'view'.
    task automatic preload(input int sel, input logic [15:0] view);
        if (sel == 1) begin
            pre1_en = 1'b1; pre1_val = rev16(view);
        end else begin
            pre2_en = 1'b1; pre2_val = {view[0], view[1]};
        end
        @(negedge CLK);
        pre1_en = 1'b0;
        pre2_en = 1'b0;
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the first SHIFT cycle.
    task automatic applyStimulus(input int sel, input logic [15:0] load, input logic cap,
                                 input logic [15:0] exp, input int lat, input bit push);
        exp_t e;
        e.data = exp;
        e.due  = cyc + lat;
        if (sel == 1) begin
            start1 = 1'b1; load1 = load; capreq1 = cap;
            if (push) q1.push_back(e);
        end else begin
            start2 = 1'b1; load2 = load[1:0]; capreq2 = cap;
            if (push) q2.push_back(e);
        end
        @(negedge CLK);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic waitDone(input int sel, input int pulse_at);
        seen = 0; en_cnt = 0; cap_cnt = 0; en_at_cap = -1; busy_low = 0; sin_seq = 2'b00;
        for (int i = 0; i < 40; i++) begin
            if (sel == 1) begin
                if (scan_en1) en_cnt++;
                if (cap_en1) begin cap_cnt++; en_at_cap = en_cnt; end
                if (!busy1) busy_low++;
                if (done1) begin seen = 1; break; end
            end else begin
                if (scan_en2) begin en_cnt++; sin_seq = {sin_seq[0], scan_in2}; end
                if (!busy2) busy_low++;
                if (done2) begin seen = 1; break; end
            end
            if (i == pulse_at) start1 = 1'b1;
            @(negedge CLK);
            start1 = 1'b0;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout dut%0d: got no done in 40 cycles, required done", sel);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busy_hi;
        #3 RSTB = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("rst_busy", busy1, 0);
        checkOutput("rst_done", done1, 0);
        checkOutput("rst_scan_en", scan_en1, 0);
        checkOutput("rst_scan_in", scan_in1, 0);
        checkOutput("rst_cap_en", cap_en1, 0);
        checkOutput("rst_unload", unload1, 0);
        RSTB = 1'b1;
        @(negedge CLK);

        $display("[TB] T1 reset mid-shift");
        preload(1, 16'h0000);
        applyStimulus(1, 16'hFFFF, 1'b0, 16'h0000, 17, 0);
        repeat (4) @(negedge CLK);
        checkOutput("t1_scan_en_before", scan_en1, 1);
        #2 RSTB = 1'b0;
        #1;
        checkOutput("t1_scan_en", scan_en1, 0);
        checkOutput("t1_cap_en", cap_en1, 0);
        checkOutput("t1_busy", busy1, 0);
        checkOutput("t1_done", done1, 0);
        repeat (2) @(negedge CLK);
        RSTB = 1'b1;
        @(negedge CLK);
        preload(1, 16'h1234);
        applyStimulus(1, 16'h0000, 1'b0, 16'h1234, 17, 1);
        waitDone(1, -1);
        @(negedge CLK);

        $display("[TB] T2 shift only");
        preload(1, 16'h0000);
        applyStimulus(1, 16'hA5C3, 1'b0, 16'h0000, 17, 1);
        waitDone(1, -1);
        checkOutput("t2_busy_during_run", busy_low, 0);
        checkOutput("t2_scan_en_cycles", en_cnt, 16);
        @(negedge CLK);
        applyStimulus(1, 16'h0000, 1'b0, 16'hA5C3, 17, 1);
        waitDone(1, -1);
        @(negedge CLK);

        $display("[TB] T3 capture");
        preload(1, 16'h00FF);
        applyStimulus(1, 16'h00FF, 1'b1, 16'h00FF, 18, 1);
        waitDone(1, -1);
        checkOutput("t3_scan_en_cycles", en_cnt, 16);
        checkOutput("t3_cap_en_cycles", cap_cnt, 1);
        checkOutput("t3_cap_after_shift", en_at_cap, 16);
        @(negedge CLK);
        applyStimulus(1, 16'h0000, 1'b0, 16'hFF00, 17, 1);
        waitDone(1, -1);
        @(negedge CLK);

        $display("[TB] T4 ignored start");
        applyStimulus(1, 16'h3C5A, 1'b0, 16'h0000, 17, 1);
        load1 = 16'hFFFF;
        waitDone(1, 4);
        checkOutput("t4_busy_during_run", busy_low, 0);
        start1 = 1'b1;
        @(negedge CLK);
        start1 = 1'b0;
        busy_hi = 0;
        for (int i = 0; i < 5; i++) begin
            if (busy1) busy_hi++;
            @(negedge CLK);
        end
        checkOutput("t4_no_second_run", busy_hi, 0);

        $display("[TB] T6 back-to-back");
        applyStimulus(1, 16'h6B29, 1'b0, 16'h3C5A, 17, 1);
        waitDone(1, -1);
        checkOutput("t6_busy_in_done", busy1, 1);
        @(negedge CLK);
        checkOutput("t6_busy_idle", busy1, 0);
        applyStimulus(1, 16'h0000, 1'b0, 16'h6B29, 17, 1);
        checkOutput("t6_busy_again", busy1, 1);
        waitDone(1, -1);
        @(negedge CLK);

        $display("[TB] T5 two-flop chain");
        preload(2, 16'h0001);
        applyStimulus(2, 16'h0002, 1'b0, 16'h0001, 3, 1);
        waitDone(2, -1);
        checkOutput("t5_scan_en_cycles", en_cnt, 2);
        checkOutput("t5_scan_in_seq", sin_seq, 2'b01);
        @(negedge CLK);
        applyStimulus(2, 16'h0000, 1'b0, 16'h0002, 3, 1);
        waitDone(2, -1);
        @(negedge CLK);
        checkOutput("t5_busy_after", busy2, 0);
        checkOutput("t5_cnt_max", cnt2_max, 1);

        repeat (3) @(negedge CLK);
        checkOutput("q1_drained", q1.size(), 0);
        checkOutput("q2_drained", q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
